// File: rtl/ram_loader_if.sv
// Stream-in / RAM-write-out signal bundle for the boot-time RAM loader.
// Handshake: a byte moves on a rising clock edge where in_valid && in_ready
// are both high; the source holds in_data stable while in_valid is high and
// the byte has not yet been taken, and the loader never retracts in_ready
// within a cycle (it is decoded purely from loader state).
interface ram_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_control;
  logic [15:0] ram_address;
  logic [15:0] ram_write_data;
  logic        busy;
  logic        done;
  logic        error;

  // Environment side: serial front end plus the CPU/RAM observing the loader.
  modport master (
    output start, in_valid, in_data,
    input  in_ready, ram_control, ram_address, ram_write_data, busy, done, error
  );

  // Loader side.
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, ram_control, ram_address, ram_write_data, busy, done, error
  );
endinterface

// File: rtl/ram_loader.sv
// Boot-time RAM loader: takes a little-endian length-prefixed byte stream,
// packs halfwords and writes them to consecutive RAM addresses from BASE_ADDR.
// Optional macro RAM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module ram_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic       clock,
  input  logic       reset,
  ram_loader_if.slave bus,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_LO  = 4'd1,
    S_LEN_HI  = 4'd2,
    S_DATA_LO = 4'd3,
    S_DATA_HI = 4'd4,
    S_WRITE   = 4'd5,
    S_DONE    = 4'd6,
`ifdef RAM_LOADER_CHECKSUM_EN
    S_ERROR   = 4'd7,
    S_CHECK   = 4'd8
`else
    S_ERROR   = 4'd7
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic [15:0] index;
  logic [7:0]  data_lo;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        error_q;
  logic        in_ready;
  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] index_inc;
  logic        len_too_big;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer        = bus.in_valid && in_ready;
  // Full length as it will be once the high byte lands this cycle.
  assign len_full    = {bus.in_data, count[7:0]};
  assign len_too_big = ({16'd0, len_full} > 32'(MAX_WORDS));
  assign index_inc   = index + 16'd1;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (bus.start) state_next = S_LEN_LO;
      S_LEN_LO:  if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)  state_next = S_DONE;
          else if (len_too_big)   state_next = S_ERROR;
          else                    state_next = S_DATA_LO;
        end
      end
      S_DATA_LO: if (xfer) state_next = S_DATA_HI;
      S_DATA_HI: if (xfer) state_next = S_WRITE;
      S_WRITE: begin
        if (index_inc == count) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_DATA_LO;
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          if (bus.in_data == csum) state_next = S_DONE;
          else                     state_next = S_ERROR;
        end
      end
`endif
      S_DONE:    state_next = S_IDLE;
      S_ERROR:   state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs: ready only while a byte is wanted, write strobe
  // only in WRITE, busy for the whole load except the terminal cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: in_ready = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
      S_CHECK: in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  // Length, index, halfword assembly, write registers and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= 16'd0;
      index   <= 16'd0;
      data_lo <= 8'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      error_q <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      csum    <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            error_q <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            csum    <= 8'd0;
`endif
          end
        end
        S_LEN_LO: if (xfer) count[7:0] <= bus.in_data;
        S_LEN_HI: begin
          if (xfer) begin
            count[15:8] <= bus.in_data;
            index       <= 16'd0;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            data_lo <= bus.in_data;
`ifdef RAM_LOADER_CHECKSUM_EN
            csum    <= csum ^ bus.in_data;
`endif
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            // Address wraps naturally in 16 bits.
            addr_q  <= BASE_ADDR + index;
            wdata_q <= {bus.in_data, data_lo};
`ifdef RAM_LOADER_CHECKSUM_EN
            csum    <= csum ^ bus.in_data;
`endif
          end
        end
        S_WRITE: index <= index_inc;
        default: ;
      endcase
      if (state != S_ERROR && state_next == S_ERROR) error_q <= 1'b1;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.ram_control    = (state == S_WRITE);
  assign bus.ram_address    = addr_q;
  assign bus.ram_write_data = wdata_q;
  assign bus.busy           = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign bus.done           = (state == S_DONE);
  assign bus.error          = error_q;
  assign state_dbg          = state;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (BASE_ADDR 0 and 16'hFFFF) share one
// input stream; a behavioural model predicts every RAM write and outcome.
module tb_ram_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       tb_start;
  logic       tb_valid;
  logic [7:0] tb_data;
  logic [3:0] dbg0, dbg1;

  int checks = 0;
  int errors = 0;
  int wr_cnt0 = 0;
  int wr_cnt1 = 0;
  int w0_base, w1_base;
  bit last_err = 1'b0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [7:0]  stream_q[$];

  typedef struct packed {
    logic [0:9][7:0] b;
    logic [3:0]      len;
    logic [6:0]      vpct;
    logic            poke;
    logic            e_done;
    logic            e_err;
    logic [3:0]      e_nw;
  } vec_t;

  vec_t vecs[5];

  ram_loader_if if0 ();
  ram_loader_if if1 ();

  assign if0.start = tb_start;
  assign if0.in_valid = tb_valid;
  assign if0.in_data = tb_data;
  assign if1.start = tb_start;
  assign if1.in_valid = tb_valid;
  assign if1.in_data = tb_data;

  ram_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave), .state_dbg(dbg0)
  );
  ram_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(256)) dut1 (
    .clock(clock), .reset(reset), .bus(if1.slave), .state_dbg(dbg1)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derive the writes and outcome straight from the stream.
  task automatic model_load(output bit m_done, output bit m_err, output int m_nw);
    int n;
    logic [7:0] x;
    logic [15:0] w;
    n = int'({stream_q[1], stream_q[0]});
    x = 8'd0;
    m_done = 1'b0;
    m_err = 1'b0;
    m_nw = 0;
    if (n == 0) m_done = 1'b1;
    else if (n > 256) m_err = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        w = {stream_q[3 + 2*i], stream_q[2 + 2*i]};
        x = x ^ stream_q[2 + 2*i] ^ stream_q[3 + 2*i];
        exp_q0.push_back({16'(i), w});
        exp_q1.push_back({16'hFFFF + 16'(i), w});
      end
      m_nw = n;
`ifdef RAM_LOADER_CHECKSUM_EN
      if (stream_q[2 + 2*n] == x) m_done = 1'b1;
      else m_err = 1'b1;
`else
      m_done = 1'b1;
`endif
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ctl0"}, {27'd0, if0.in_ready, if0.ram_control, if0.busy, if0.done, if0.error}, 32'd0);
    check({tag, " ctl1"}, {27'd0, if1.in_ready, if1.ram_control, if1.busy, if1.done, if1.error}, 32'd0);
    check({tag, " bus0"}, {if0.ram_address, if0.ram_write_data}, 32'd0);
    check({tag, " bus1"}, {if1.ram_address, if1.ram_write_data}, 32'd0);
  endtask

  // Driver: pulse start from IDLE, then push stream_q with random valid gaps.
  task automatic send_stream(input int vpct, input bit poke, input string tag);
    int budget;
    bit sent;
    check({tag, " error_held0"}, 32'(if0.error), 32'(last_err));
    check({tag, " error_held1"}, 32'(if1.error), 32'(last_err));
    w0_base = wr_cnt0;
    w1_base = wr_cnt1;
    tb_start = 1'b1;
    @(negedge clock);
    tb_start = 1'b0;
    #1;
    check({tag, " busy_after_start"}, {30'd0, if0.busy, if1.busy}, 32'd3);
    check({tag, " error_cleared"}, {30'd0, if0.error, if1.error}, 32'd0);
    for (int k = 0; k < stream_q.size(); k++) begin
      sent = 1'b0;
      budget = 0;
      while (!sent && budget < 300) begin
        tb_valid = ($urandom_range(99) < vpct);
        tb_data = tb_valid ? stream_q[k] : 8'($urandom);
        if (poke) tb_start = 1'($urandom_range(1));
        #1;
        sent = tb_valid && if0.in_ready;
        budget++;
        @(negedge clock);
      end
      if (!sent) begin
        checks++;
        errors++;
        $display("FAIL %s stall_timeout: byte %0d not taken in %0d cycles", tag, k, budget);
        break;
      end
    end
    tb_valid = 1'b0;
    tb_start = 1'b0;
  endtask

  // Observe the tail of a load and compare the outcome.
  task automatic finish_window(input bit e_done, input bit e_err, input int e_nw, input string tag);
    int dc0, dc1;
    dc0 = 0;
    dc1 = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (if0.done) begin
        dc0++;
        check({tag, " busy_with_done"}, 32'(if0.busy), 32'd0);
      end
      if (if1.done) dc1++;
      @(negedge clock);
    end
    #1;
    check({tag, " done_pulses0"}, 32'(dc0), 32'(e_done));
    check({tag, " done_pulses1"}, 32'(dc1), 32'(e_done));
    check({tag, " error"}, {30'd0, if0.error, if1.error}, e_err ? 32'd3 : 32'd0);
    check({tag, " idle_flags"}, {29'd0, if0.busy, if1.busy, if0.in_ready}, 32'd0);
    check({tag, " writes0"}, 32'(wr_cnt0 - w0_base), 32'(e_nw));
    check({tag, " writes1"}, 32'(wr_cnt1 - w1_base), 32'(e_nw));
    check({tag, " pending"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    last_err = e_err;
  endtask

  task automatic load_vec(input vec_t v, input string tag);
    bit md, me;
    int mn;
    stream_q.delete();
    for (int k = 0; k < int'(v.len); k++) stream_q.push_back(v.b[k]);
    model_load(md, me, mn);
    send_stream(int'(v.vpct), v.poke, tag);
    finish_window(v.e_done, v.e_err, int'(v.e_nw), tag);
  endtask

  initial begin
    bit md, me;
    int mn, n;
    logic [7:0] x, b;

`ifdef RAM_LOADER_CHECKSUM_EN
    vecs[0] = '{b: 80'h02_00_34_12_CD_AB_40_00_00_00, len: 4'd7, vpct: 7'd100, poke: 1'b0, e_done: 1'b1, e_err: 1'b0, e_nw: 4'd2};
    vecs[3] = '{b: 80'h02_00_34_12_CD_AB_41_00_00_00, len: 4'd7, vpct: 7'd50,  poke: 1'b1, e_done: 1'b0, e_err: 1'b1, e_nw: 4'd2};
    vecs[4] = '{b: 80'h01_00_78_56_2E_00_00_00_00_00, len: 4'd5, vpct: 7'd70,  poke: 1'b1, e_done: 1'b1, e_err: 1'b0, e_nw: 4'd1};
`else
    vecs[0] = '{b: 80'h02_00_34_12_CD_AB_00_00_00_00, len: 4'd6, vpct: 7'd100, poke: 1'b0, e_done: 1'b1, e_err: 1'b0, e_nw: 4'd2};
    vecs[3] = '{b: 80'h02_00_34_12_CD_AB_00_00_00_00, len: 4'd6, vpct: 7'd50,  poke: 1'b1, e_done: 1'b1, e_err: 1'b0, e_nw: 4'd2};
    vecs[4] = '{b: 80'h01_00_78_56_00_00_00_00_00_00, len: 4'd4, vpct: 7'd70,  poke: 1'b1, e_done: 1'b1, e_err: 1'b0, e_nw: 4'd1};
`endif
    vecs[1] = '{b: 80'h00_00_00_00_00_00_00_00_00_00, len: 4'd2, vpct: 7'd100, poke: 1'b0, e_done: 1'b1, e_err: 1'b0, e_nw: 4'd0};
    vecs[2] = '{b: 80'h01_01_00_00_00_00_00_00_00_00, len: 4'd2, vpct: 7'd100, poke: 1'b0, e_done: 1'b0, e_err: 1'b1, e_nw: 4'd0};

    // Scoreboard monitor: every write strobe must match the head of the queue.
    fork
      forever begin
        @(negedge clock);
        if (if0.ram_control === 1'b1) begin
          wr_cnt0++;
          if (exp_q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write0_unexpected: got %h expected none", {if0.ram_address, if0.ram_write_data});
          end else check("write0", {if0.ram_address, if0.ram_write_data}, exp_q0.pop_front());
        end
        if (if1.ram_control === 1'b1) begin
          wr_cnt1++;
          if (exp_q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write1_unexpected: got %h expected none", {if1.ram_address, if1.ram_write_data});
          end else check("write1", {if1.ram_address, if1.ram_write_data}, exp_q1.pop_front());
        end
      end
    join_none

    // Reset.
    reset = 1'b1;
    tb_start = 1'b1;
    tb_valid = 1'b0;
    tb_data = 8'd0;
    repeat (3) @(negedge clock);
    #1;
    check_idle("reset");
    reset = 1'b0;
    tb_start = 1'b0;
    @(negedge clock);

    // Table-driven loads.
    for (int v = 0; v < 5; v++) load_vec(vecs[v], $sformatf("vec%0d", v));

    // Reset after the first of three words.
    stream_q.delete();
    stream_q.push_back(8'h03);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h11);
    stream_q.push_back(8'h22);
    exp_q0.push_back({16'h0000, 16'h2211});
    exp_q1.push_back({16'hFFFF, 16'h2211});
    send_stream(100, 1'b0, "rst_mid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle("rst_mid");
    check("rst_mid writes0", 32'(wr_cnt0 - w0_base), 32'd1);
    check("rst_mid pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    last_err = 1'b0;
    @(negedge clock);
    stream_q.delete();
    stream_q.push_back(8'h01);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'hEF);
    stream_q.push_back(8'hBE);
`ifdef RAM_LOADER_CHECKSUM_EN
    stream_q.push_back(8'h51);
`endif
    model_load(md, me, mn);
    send_stream(100, 1'b0, "after_rst");
    finish_window(1'b1, 1'b0, 1, "after_rst");

    // Randomized loads against the model.
    for (int r = 0; r < 12; r++) begin
      stream_q.delete();
      n = ($urandom_range(4) == 0) ? int'($urandom_range(600, 257)) : int'($urandom_range(6, 1));
      stream_q.push_back(8'(n));
      stream_q.push_back(8'(n >> 8));
      x = 8'd0;
      if (n <= 256) begin
        for (int k = 0; k < 2*n; k++) begin
          b = 8'($urandom);
          x = x ^ b;
          stream_q.push_back(b);
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        stream_q.push_back(($urandom_range(1) == 1) ? x : (x ^ 8'($urandom_range(255, 1))));
`endif
      end
      model_load(md, me, mn);
      send_stream(int'($urandom_range(100, 30)), 1'($urandom_range(1)), $sformatf("rand%0d", r));
      finish_window(md, me, mn, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
